// File: rtl/mirfak_div_issue.sv
// mirfak_div_issue
// Issue-side requester for the Mirfak 32-bit iterative divider.
// It takes a divide-class instruction from EX and holds its operands and
// command steady on the divider interface. EX is stalled until the divider
// acks. The requester then returns a one-cycle result pulse. An operation
// killed by a flush is drained, because the divider cannot be aborted.
//
// Optional feature: define MIRFAK_DIV_CACHE_EN to add a one-entry result cache.
// A request that exactly matches the last completed operation then bypasses
// the divider.
//
// Ports
//   clk_i          core clock, shared with the divider
//   rstn_i         synchronous active-low reset
//   ex_req_i       EX holds a valid DIV/DIVU/REM/REMU
//   ex_cmd_i       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   ex_op1_i       dividend
//   ex_op2_i       divisor
//   ex_kill_i      flush of the EX instruction
//   stall_o        hold EX (combinational)
//   result_o       quotient or remainder
//   result_valid_o one-cycle pulse, result consumed
//   div_op1/div_op2/div_cmd/div_enable  registered divider request
//   div_result/div_ack                  divider response
module mirfak_div_issue (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        ex_req_i,
    input  logic [1:0]  ex_cmd_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        ex_kill_i,
    output logic        stall_o,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic [1:0]  div_cmd,
    output logic        div_enable,
    input  logic [31:0] div_result,
    input  logic        div_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [1:0]  cmd_q, cmd_d;
    logic        en_q, en_d;
    logic [31:0] res_q, res_d;
    logic        accept;
    logic        cache_hit;

    assign accept = ex_req_i && !ex_kill_i;

`ifdef MIRFAK_DIV_CACHE_EN
    logic        c_valid_q;
    logic [31:0] c_op1_q, c_op2_q, c_res_q;
    logic [1:0]  c_cmd_q;
    logic        cache_wr;

    assign cache_hit = c_valid_q && (c_op1_q == ex_op1_i) &&
                       (c_op2_q == ex_op2_i) && (c_cmd_q == ex_cmd_i);
    // Only a completed ack that was not flushed may populate the entry.
    assign cache_wr  = (state_q == S_BUSY) && div_ack && !ex_kill_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            c_valid_q <= 1'b0;
            c_op1_q   <= '0;
            c_op2_q   <= '0;
            c_cmd_q   <= '0;
            c_res_q   <= '0;
        end else if (cache_wr) begin
            c_valid_q <= 1'b1;
            c_op1_q   <= op1_q;
            c_op2_q   <= op2_q;
            c_cmd_q   <= cmd_q;
            c_res_q   <= div_result;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cmd_d   = cmd_q;
        en_d    = en_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cache_hit) begin
`ifdef MIRFAK_DIV_CACHE_EN
                        res_d   = c_res_q;
`endif
                        state_d = S_DONE;
                    end else begin
                        op1_d   = ex_op1_i;
                        op2_d   = ex_op2_i;
                        cmd_d   = ex_cmd_i;
                        en_d    = 1'b1;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (div_ack) begin
                    // The ack dequeues the divider even when EX is flushed
                    // in the same cycle. Only the result pulse is dropped.
                    en_d = 1'b0;
                    if (ex_kill_i) begin
                        state_d = S_IDLE;
                    end else begin
                        res_d   = div_result;
                        state_d = S_DONE;
                    end
                end else if (ex_kill_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                // Passing through IDLE guarantees the enable-low gap the
                // divider needs before it re-arms.
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (div_ack) begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            cmd_q   <= '0;
            en_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cmd_q   <= cmd_d;
            en_q    <= en_d;
            res_q   <= res_d;
        end
    end

    assign stall_o        = accept && (state_q != S_DONE);
    assign result_valid_o = (state_q == S_DONE);
    assign result_o       = res_q;
    assign div_op1        = op1_q;
    assign div_op2        = op2_q;
    assign div_cmd        = cmd_q;
    assign div_enable     = en_q;

endmodule

// File: tb/tb_mirfak_div_issue.sv
module tb_mirfak_div_issue;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        ex_req_i;
    logic [1:0]  ex_cmd_i;
    logic [31:0] ex_op1_i;
    logic [31:0] ex_op2_i;
    logic        ex_kill_i;
    logic        stall_o;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [1:0]  div_cmd;
    logic        div_enable;
    logic [31:0] div_result;
    logic        div_ack;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    always #5 clk_i = ~clk_i;

    mirfak_div_issue dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .ex_req_i      (ex_req_i),
        .ex_cmd_i      (ex_cmd_i),
        .ex_op1_i      (ex_op1_i),
        .ex_op2_i      (ex_op2_i),
        .ex_kill_i     (ex_kill_i),
        .stall_o       (stall_o),
        .result_o      (result_o),
        .result_valid_o(result_valid_o),
        .div_op1       (div_op1),
        .div_op2       (div_op2),
        .div_cmd       (div_cmd),
        .div_enable    (div_enable),
        .div_result    (div_result),
        .div_ack       (div_ack)
    );

    // Divider stand-in: ack goes high 35 edges after enable is first set,
    // and the result is computed from the request held at completion.
    function automatic logic [31:0] div_model(input logic [1:0] c,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        sa  = a;
        sbv = b;
        case (c)
            2'b00: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sbv;
            end
            2'b01: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            2'b10: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sbv;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    int cnt;
    always @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt        <= 0;
            div_ack    <= 1'b0;
            div_result <= 32'd0;
        end else if (div_ack) begin
            div_ack <= 1'b0;
            cnt     <= 0;
        end else if (div_enable) begin
            if (cnt == 34) begin
                div_ack    <= 1'b1;
                div_result <= div_model(div_cmd, div_op1, div_op2);
            end
            cnt <= cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive a request at the current negedge and follow it until the result
    // pulse. lat is the negedge index of the expected pulse, thru says the
    // divider is used, pre_hi counts leading cycles of a still-draining op.
    // Returns at the DONE negedge with the request still driven.
    task automatic do_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit thru, input int pre_hi);
        bit got;
        logic exp_en;
        logic [31:0] w;
        ex_req_i = 1'b1;
        ex_cmd_i = c;
        ex_op1_i = a;
        ex_op2_i = b;
        sb.push_back(exp);
        got = 1'b0;
        for (int k = 1; k <= lat + 4 && !got; k++) begin
            @(negedge clk_i);
            if (result_valid_o) begin
                got = 1'b1;
                chk("latency", k, lat);
                chk("stall_in_done", {31'd0, stall_o}, 32'd0);
                chk("sb_depth", sb.size(), 32'd1);
                if (sb.size() > 0) begin
                    w = sb.pop_front();
                    chk("result", result_o, w);
                end
            end else if (k < lat) begin
                chk("stall_busy", {31'd0, stall_o}, 32'd1);
                exp_en = (thru && k >= lat - 36) || (k <= pre_hi);
                chk("enable", {31'd0, div_enable}, {31'd0, exp_en});
                if (thru && k >= lat - 36) begin
                    chk("op1_stable", div_op1, a);
                    chk("op2_stable", div_op2, b);
                    chk("cmd_stable", {30'd0, div_cmd}, {30'd0, c});
                end
            end
        end
        if (!got) begin
            chk("valid_timeout", {31'd0, result_valid_o}, 32'd1);
            sb.delete();
        end
    endtask

    task automatic idle_gap();
        ex_req_i = 1'b0;
        @(negedge clk_i);
        chk("single_pulse", {31'd0, result_valid_o}, 32'd0);
        chk("enable_after", {31'd0, div_enable}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2'b01, 32'd100,        32'd7,          32'd14};
        vt[1] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vt[2] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vt[3] = '{2'b00, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA};
        vt[4] = '{2'b11, 32'hFFFF_FFFF,  32'd16,         32'd15};
        vt[5] = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vt[6] = '{2'b10, 32'd5,          32'd0,          32'd5};
        vt[7] = '{2'b10, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE};

        rstn_i = 1'b0; ex_req_i = 1'b0; ex_kill_i = 1'b0;
        ex_cmd_i = 2'b00; ex_op1_i = 32'd0; ex_op2_i = 32'd0;
        repeat (3) @(negedge clk_i);
        chk("rst_enable", {31'd0, div_enable}, 32'd0);
        chk("rst_op1", div_op1, 32'd0);
        chk("rst_op2", div_op2, 32'd0);
        chk("rst_cmd", {30'd0, div_cmd}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_valid", {31'd0, result_valid_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Table: first from IDLE, the rest back-to-back out of DONE.
        for (int i = 0; i < 8; i++)
            do_op(vt[i].cmd, vt[i].a, vt[i].b, vt[i].exp, (i == 0) ? 37 : 38, 1'b1, 0);
        idle_gap();
        chk("stall_idle", {31'd0, stall_o}, 32'd0);

        // Kill 10 cycles into BUSY, then a request that waits out DRAIN.
        ex_req_i = 1'b1; ex_cmd_i = 2'b00; ex_op1_i = 32'd5; ex_op2_i = 32'd0;
        repeat (10) @(negedge clk_i);
        chk("busy_enable", {31'd0, div_enable}, 32'd1);
        ex_kill_i = 1'b1;
        #1;
        chk("stall_kill", {31'd0, stall_o}, 32'd0);
        @(negedge clk_i);
        chk("drain_no_valid", {31'd0, result_valid_o}, 32'd0);
        chk("drain_enable", {31'd0, div_enable}, 32'd1);
        ex_kill_i = 1'b0;
        do_op(2'b01, 32'd9, 32'd3, 32'd3, 63, 1'b1, 25);
        idle_gap();

        // Kill coincident with ack: no pulse, back to IDLE, no cache fill.
        ex_req_i = 1'b1; ex_cmd_i = 2'b01; ex_op1_i = 32'd77; ex_op2_i = 32'd7;
        repeat (36) @(negedge clk_i);
        ex_kill_i = 1'b1;
        #1;
        chk("stall_killack", {31'd0, stall_o}, 32'd0);
        @(negedge clk_i);
        chk("killack_valid", {31'd0, result_valid_o}, 32'd0);
        chk("killack_enable", {31'd0, div_enable}, 32'd0);
        ex_kill_i = 1'b0; ex_req_i = 1'b0;
        @(negedge clk_i);
        chk("killack_valid2", {31'd0, result_valid_o}, 32'd0);
        do_op(2'b01, 32'd77, 32'd7, 32'd11, 37, 1'b1, 0);
        idle_gap();

        // Reset pulse mid-BUSY.
        ex_req_i = 1'b1; ex_cmd_i = 2'b01; ex_op1_i = 32'd50; ex_op2_i = 32'd5;
        repeat (10) @(negedge clk_i);
        rstn_i = 1'b0; ex_req_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        chk("mrst_enable", {31'd0, div_enable}, 32'd0);
        chk("mrst_valid", {31'd0, result_valid_o}, 32'd0);
        chk("mrst_result", result_o, 32'd0);
        chk("mrst_op1", div_op1, 32'd0);
        repeat (3) begin
            @(negedge clk_i);
            chk("mrst_quiet", {31'd0, result_valid_o}, 32'd0);
        end
        do_op(2'b01, 32'd8, 32'd2, 32'd4, 37, 1'b1, 0);
        idle_gap();

        // Repeated request, then a different command on the same operands.
        do_op(2'b01, 32'd1000, 32'd10, 32'd100, 37, 1'b1, 0);
`ifdef MIRFAK_DIV_CACHE_EN
        do_op(2'b01, 32'd1000, 32'd10, 32'd100, 2, 1'b0, 0);
`else
        do_op(2'b01, 32'd1000, 32'd10, 32'd100, 38, 1'b1, 0);
`endif
        do_op(2'b11, 32'd1000, 32'd10, 32'd0, 38, 1'b1, 0);
        idle_gap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
